// File: rtl/scan_sel_gen.sv
// scan_sel_gen: select/enable sequencer for a 3-to-8 decoder scanning 8 masked lines.
// Define SCAN_REVERSE_EN to add a `dir` input for descending scan order.
module scan_sel_gen #(
    parameter int PRESCALE  = 4,
    parameter int BLANK_CYC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [7:0] mask,
`ifdef SCAN_REVERSE_EN
    input  logic       dir,
`endif
    output logic       e,
    output logic [2:0] w,
    output logic       frame_done
);
    typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_t;
    state_t      state_q, state_d;
    logic        e_q, e_d;
    logic [2:0]  w_q, w_d;
    logic        fd_q, fd_d;
    logic [15:0] cnt_q, cnt_d;
    logic        down;
    logic [3:0]  start_s, next_s;
    logic        next_wrap, dwell_end, blank_end;
`ifdef SCAN_REVERSE_EN
    assign down = dir;
`else
    assign down = 1'b0;
`endif
    // {found, index}: nearest set bit after cur in scan direction; cur itself is tried last
    function automatic logic [3:0] find_next(input logic [7:0] m, input logic [2:0] cur, input logic dn);
        logic [3:0] r;
        logic [2:0] idx;
        r = '0;
        for (int k = 8; k >= 1; k--) begin
            idx = dn ? cur - 3'(k) : cur + 3'(k);
            if (m[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction
    always_comb begin
        start_s   = find_next(mask, down ? 3'd0 : 3'd7, down);
        next_s    = find_next(mask, w_q, down);
        next_wrap = down ? (next_s[2:0] >= w_q) : (next_s[2:0] <= w_q);
        dwell_end = (state_q == ACTIVE) && (cnt_q == 16'(PRESCALE - 1));
        blank_end = (state_q == BLANK) && (cnt_q == 16'(BLANK_CYC - 1));
        state_d   = state_q;
        e_d       = e_q;
        w_d       = w_q;
        fd_d      = 1'b0;
        cnt_d     = cnt_q + 16'd1;
        if (!run) begin
            state_d = IDLE;
            e_d     = 1'b0;
            cnt_d   = '0;
        end else if (state_q == IDLE) begin
            cnt_d = '0;
            if (start_s[3]) begin
                state_d = ACTIVE;
                e_d     = 1'b1;
                w_d     = start_s[2:0];
            end
        end else if ((dwell_end && BLANK_CYC == 0) || blank_end) begin
            cnt_d   = '0;
            state_d = next_s[3] ? ACTIVE : IDLE;
            e_d     = next_s[3];
            w_d     = next_s[3] ? next_s[2:0] : w_q;
            fd_d    = next_s[3] & next_wrap;
        end else if (dwell_end) begin
            state_d = BLANK;
            e_d     = 1'b0;
            cnt_d   = '0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            e_q     <= 1'b0;
            w_q     <= '0;
            fd_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            e_q     <= e_d;
            w_q     <= w_d;
            fd_q    <= fd_d;
            cnt_q   <= cnt_d;
        end
    end
    assign e          = e_q;
    assign w          = w_q;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_scan_sel_gen.sv
// tb_scan_sel_gen: two configurations (with and without blanking) checked every cycle against a line-period model.
module tb_scan_sel_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [7:0] mask = 8'h00;
    logic       e_o[2];
    logic [2:0] w_o[2];
    logic       fd_o[2];
    int n_chk = 0;
    int n_err = 0;
    int pre[2] = '{4, 3};
    int blk[2] = '{1, 0};
    bit m_on[2];
    int m_t[2];
    int m_w[2];
    bit m_fd[2];
    always #5 clk = ~clk;
    scan_sel_gen #(.PRESCALE(4), .BLANK_CYC(1)) u0 (
        .clk(clk), .rst(rst), .run(run), .mask(mask),
`ifdef SCAN_REVERSE_EN
        .dir(1'b0),
`endif
        .e(e_o[0]), .w(w_o[0]), .frame_done(fd_o[0]));
    scan_sel_gen #(.PRESCALE(3), .BLANK_CYC(0)) u1 (
        .clk(clk), .rst(rst), .run(run), .mask(mask),
`ifdef SCAN_REVERSE_EN
        .dir(1'b0),
`endif
        .e(e_o[1]), .w(w_o[1]), .frame_done(fd_o[1]));
    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_on[i] = 0; m_t[i] = 0; m_w[i] = 0; m_fd[i] = 0;
        end
    endtask
    // One line period is pre+blk cycles; e is high for the first pre of them
    task automatic model_edge();
        int nxt;
        for (int i = 0; i < 2; i++) begin
            m_fd[i] = 0;
            if (rst) begin
                m_on[i] = 0; m_t[i] = 0; m_w[i] = 0;
            end else if (!run) begin
                m_on[i] = 0; m_t[i] = 0;
            end else if (!m_on[i]) begin
                for (int b = 7; b >= 0; b--)
                    if (mask[b]) begin m_on[i] = 1; m_w[i] = b; m_t[i] = 0; end
            end else begin
                m_t[i]++;
                if (m_t[i] == pre[i] + blk[i]) begin
                    m_t[i] = 0;
                    nxt = -1;
                    for (int k = 1; k <= 8; k++)
                        if (nxt < 0 && mask[(m_w[i] + k) % 8]) nxt = (m_w[i] + k) % 8;
                    if (nxt < 0) m_on[i] = 0;
                    else begin
                        m_fd[i] = (nxt <= m_w[i]);
                        m_w[i] = nxt;
                    end
                end
            end
        end
    endtask
    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("e%0d", i), int'(e_o[i]), int'(m_on[i] && m_t[i] < pre[i]));
            chk($sformatf("w%0d", i), int'(w_o[i]), m_w[i]);
            chk($sformatf("fd%0d", i), int'(fd_o[i]), int'(m_fd[i]));
        end
    endtask
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask
    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask
    task automatic wait_w(input int val);
        for (int i = 0; i < 200 && !(w_o[0] == 3'(val) && e_o[0]); i++) step();
        chk("wait_w", int'(w_o[0]), val);
    endtask
    initial begin
        model_reset();
        steps(2);
        rst = 1'b0;
        steps(2);
        run = 1'b1; mask = 8'hFF;
        steps(100);
        mask = 8'b1010_0100;
        steps(60);
        mask = 8'h10;
        steps(20);
        mask = 8'h00;
        steps(12);
        mask = 8'hFF;
        wait_w(3);
        step();
        run = 1'b0;
        steps(3);
        run = 1'b1;
        steps(20);
        wait_w(6);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_e", int'(e_o[0]), 0);
        chk("arst_w", int'(w_o[0]), 0);
        chk("arst_fd", int'(fd_o[0]), 0);
        chk("arst_e1", int'(e_o[1]), 0);
        @(negedge clk) rst = 1'b0;
        steps(5);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 59) == 0) run = ~run;
            if ($urandom_range(0, 29) == 0) begin
                case ($urandom_range(0, 7))
                    0: mask = 8'h00;
                    1, 2: mask = 8'(1 << $urandom_range(0, 7));
                    default: mask = 8'($urandom);
                endcase
            end
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
